// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register pair with pipelined multiply and iterative restoring divide
module hilo_muldiv #(
    parameter int MUL_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    input  logic        hi_writeW,
    input  logic        lo_writeW,
    input  logic [31:0] hiW,
    input  logic [31:0] loW,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_t;

    localparam int MCW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
    localparam logic [MCW-1:0] MUL_LAST = MCW'(MUL_STAGES - 1);

    state_t         state;
    logic [31:0]    hi_r;
    logic [31:0]    lo_r;
    logic [63:0]    mul_pipe [MUL_STAGES];
    logic [MCW-1:0] mul_cnt;
    logic [4:0]     div_cnt;
    logic [31:0]    div_q;
    logic [31:0]    div_rem;
    logic [31:0]    div_d;
    logic [31:0]    div_a_raw;
    logic           div_sa;
    logic           div_sb;
    logic           div_zero;

    logic [63:0]    a_ext;
    logic [63:0]    b_ext;
    logic [63:0]    mul_prod;
    logic [31:0]    a_mag;
    logic [31:0]    b_mag;
    logic [32:0]    div_shift;
    logic           div_ge;
    logic [31:0]    div_sub;
    logic [31:0]    rem_next;
    logic [31:0]    q_next;
    logic           res_valid;
    logic [31:0]    res_hi;
    logic [31:0]    res_lo;

    // Sign- or zero-extend to 64 bits so one multiplier serves MULT and MULTU.
    always_comb begin
        a_ext    = op[0] ? {32'b0, a} : {{32{a[31]}}, a};
        b_ext    = op[0] ? {32'b0, b} : {{32{b[31]}}, b};
        mul_prod = a_ext * b_ext;
        a_mag    = (!op[0] && a[31]) ? -a : a;
        b_mag    = (!op[0] && b[31]) ? -b : b;
    end

    always_comb begin
        div_shift = {div_rem, div_q[31]};
        div_ge    = div_shift >= {1'b0, div_d};
        div_sub   = div_shift[31:0] - div_d;
        rem_next  = div_ge ? div_sub : div_shift[31:0];
        q_next    = {div_q[30:0], div_ge};
    end

    always_comb begin
        res_valid = 1'b0;
        res_hi    = '0;
        res_lo    = '0;
        if (state == S_MUL && mul_cnt == MUL_LAST) begin
            res_valid = 1'b1;
            res_hi    = mul_pipe[MUL_STAGES-1][63:32];
            res_lo    = mul_pipe[MUL_STAGES-1][31:0];
        end else if (state == S_DIV && div_cnt == 5'd31) begin
            res_valid = 1'b1;
            if (div_zero) begin
                res_hi = div_a_raw;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = div_sa ? -rem_next : rem_next;
                res_lo = (div_sa ^ div_sb) ? -q_next : q_next;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign hi_o = hi_writeW ? hiW : hi_r;
    assign lo_o = lo_writeW ? loW : lo_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            hi_r      <= '0;
            lo_r      <= '0;
            done      <= 1'b0;
            mul_cnt   <= '0;
            div_cnt   <= '0;
            div_q     <= '0;
            div_rem   <= '0;
            div_d     <= '0;
            div_a_raw <= '0;
            div_sa    <= 1'b0;
            div_sb    <= 1'b0;
            div_zero  <= 1'b0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                mul_pipe[i] <= '0;
            end
        end else begin
            done <= res_valid;
            // Writeback owns whichever half it writes; the other half still takes the result.
            hi_r <= hi_writeW ? hiW : (res_valid ? res_hi : hi_r);
            lo_r <= lo_writeW ? loW : (res_valid ? res_lo : lo_r);
            for (int i = 1; i < MUL_STAGES; i++) begin
                mul_pipe[i] <= mul_pipe[i-1];
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (op[1]) begin
                            div_q     <= a_mag;
                            div_rem   <= '0;
                            div_d     <= b_mag;
                            div_a_raw <= a;
                            div_sa    <= !op[0] && a[31];
                            div_sb    <= !op[0] && b[31];
                            div_zero  <= (b == 32'd0);
                            div_cnt   <= '0;
                            state     <= S_DIV;
                        end else begin
                            mul_pipe[0] <= mul_prod;
                            mul_cnt     <= '0;
                            state       <= S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_cnt == MUL_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        mul_cnt <= mul_cnt + MCW'(1);
                    end
                end
                S_DIV: begin
                    div_q   <= q_next;
                    div_rem <= rem_next;
                    if (div_cnt == 5'd31) begin
                        state <= S_IDLE;
                    end else begin
                        div_cnt <= div_cnt + 5'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - directed vector bench for hilo_muldiv
module tb_hilo_muldiv;

    localparam int MS = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        hi_writeW;
    logic        lo_writeW;
    logic [31:0] hiW;
    logic [31:0] loW;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hilo_muldiv #(.MUL_STAGES(MS)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .hi_writeW(hi_writeW),
        .lo_writeW(lo_writeW),
        .hiW      (hiW),
        .loW      (loW),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where done is expected high.
    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int guard;
        string tag;
        tag   = $sformatf("v%0d", idx);
        op    = v.op;
        a     = v.a;
        b     = v.b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_accept"}, {31'b0, busy}, 32'd1);
        check({tag, "_done_low"}, {31'b0, done}, 32'd0);
        lat   = 1;
        guard = 0;
        while (busy === 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
            if (busy === 1'b1) lat++;
        end
        check({tag, "_latency"}, lat, v.lat);
        check({tag, "_done"}, {31'b0, done}, 32'd1);
        check({tag, "_hi"}, hi_o, v.hi);
        check({tag, "_lo"}, lo_o, v.lo);
    endtask

    initial begin
        int  busy_seen;
        int  done_seen;
        vecs[0]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MS};
        vecs[1]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MS};
        vecs[2]  = '{2'b01, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, MS};
        vecs[3]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, MS};
        vecs[4]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32};
        vecs[5]  = '{2'b11, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF, 32};
        vecs[6]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 32};
        vecs[7]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 32};
        vecs[8]  = '{2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32};
        vecs[9]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 32};
        vecs[10] = '{2'b01, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, MS};

        resetn    = 1'b0;
        start     = 1'b0;
        op        = 2'b00;
        a         = '0;
        b         = '0;
        hi_writeW = 1'b0;
        lo_writeW = 1'b0;
        hiW       = '0;
        loW       = '0;

        #12;
        check("rst_hi", hi_o, 32'd0);
        check("rst_lo", lo_o, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_hi", hi_o, 32'd0);
        check("idle_lo", lo_o, 32'd0);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_done", {31'b0, done}, 32'd0);

        // Back-to-back: each vector starts in the cycle the previous done is high.
        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // MULTU with start pulses while busy that must be ignored.
        op    = 2'b01;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        check("ign_busy0", {31'b0, busy}, 32'd1);
        op    = 2'b10;
        a     = 32'd50;
        b     = 32'd5;
        @(negedge clk);
        check("ign_busy1", {31'b0, busy}, 32'd1);
        start = 1'b0;
        @(negedge clk);
        check("ign_done", {31'b0, done}, 32'd1);
        check("ign_hi", hi_o, 32'hFFFF_FFFE);
        check("ign_lo", lo_o, 32'h0000_0001);
        @(negedge clk);
        check("ign_idle", {31'b0, busy}, 32'd0);
        check("ign_done_clr", {31'b0, done}, 32'd0);

        // MTLO while idle: bypass this cycle, register next, HI untouched.
        lo_writeW = 1'b1;
        loW       = 32'h0000_55AA;
        #1;
        check("mtlo_bypass", lo_o, 32'h0000_55AA);
        @(negedge clk);
        lo_writeW = 1'b0;
        #1;
        check("mtlo_lo", lo_o, 32'h0000_55AA);
        check("mtlo_hi", hi_o, 32'hFFFF_FFFE);

        // DIVU 100/7 with MTHI landing on the result edge.
        @(negedge clk);
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        check("col_busy_last", {31'b0, busy}, 32'd1);
        hi_writeW = 1'b1;
        hiW       = 32'h0000_DEAD;
        #1;
        check("col_bypass", hi_o, 32'h0000_DEAD);
        @(negedge clk);
        hi_writeW = 1'b0;
        #1;
        check("col_done", {31'b0, done}, 32'd1);
        check("col_hi", hi_o, 32'h0000_DEAD);
        check("col_lo", lo_o, 32'd14);

        // Reset in the middle of a DIV aborts it without a done pulse.
        @(negedge clk);
        op    = 2'b10;
        a     = 32'd100;
        b     = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_hi", hi_o, 32'd0);
        check("abort_lo", lo_o, 32'd0);
        @(negedge clk);
        resetn    = 1'b1;
        busy_seen = 0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
            if (done !== 1'b0) done_seen++;
        end
        check("abort_no_busy", busy_seen, 32'd0);
        check("abort_no_done", done_seen, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
